lu_issue_stage: RTL
===================

// Module: lu_issue_stage
// PURPOSE
// - Upstream issue stage for the 4-function logic unit (xor/xnor/or/nor mux tree).
// - Accepts {a, b, op} requests over valid/ready and drives registered operands and selects into the LU.
// - Captures the LU result one cycle later and presents it downstream over valid/ready.
// - One transaction in flight; optional sweep mode issues all four ops for one request.
// PARAMETERS
// - WIDTH     4  operand/result width in bits; one LU slice per bit.
// - CNT_W     8  width of the saturating completed-result counter.
// PORTS
// - clk        in   1      rising-edge clock
// - reset      in   1      synchronous, active-high reset
// - in_valid   in   1      request present
// - in_ready   out  1      stage accepts request this cycle
// - in_a       in   WIDTH  operand a
// - in_b       in   WIDTH  operand b
// - in_op      in   2      {sel2,sel1}: 00 xor, 01 xnor, 10 or, 11 nor
// - lu_a       out  WIDTH  registered operand a to LU
// - lu_b       out  WIDTH  registered operand b to LU
// - lu_sel1    out  1      registered select1 to LU
// - lu_sel2    out  1      registered select2 to LU
// - lu_s       in   WIDTH  LU result, combinational from lu_* outputs
// - out_valid  out  1      result held
// - out_ready  in   1      downstream takes result
// - out_data   out  WIDTH  captured LU result
// - out_op     out  2      op that produced out_data
// - done_cnt   out  CNT_W  results delivered, saturates at all-ones
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0 except in_ready=1; done_cnt=0.
// - FSM states:
//   - IDLE: in_ready=1. On in_valid, load lu_a/lu_b/{lu_sel2,lu_sel1} from inputs, go to ISSUE.
//   - ISSUE: in_ready=0. Sample lu_s into out_data and {lu_sel2,lu_sel1} into out_op, go to OUT.
//   - OUT: out_valid=1; out_data and out_op held stable. On out_ready, done_cnt++ (saturating).
//     Without sweep, go to IDLE on out_ready.
// - Latency: accept edge at cycle N -> lu_* valid in N+1 -> out_valid=1 from N+2.
// - Throughput: one result per 3 cycles at best.
// - in_ready is a pure function of state; it is 0 in ISSUE and OUT.
// - lu_* outputs hold their last value in IDLE and OUT; they are not cleared.
// - out_valid drops the cycle after the out_ready handshake.
// - out_valid=1 with out_ready=0: hold indefinitely; no new request is accepted.
// - Reset in ISSUE or OUT: the in-flight transaction is discarded and done_cnt clears.
// - done_cnt at all-ones stays at all-ones on further handshakes.
// - Width rule: all data paths are WIDTH bits, bitwise; no arithmetic except done_cnt.
// CONFIGURATION
// - LU_SWEEP_EN defined:
//   - An accepted request ignores in_op and issues ops 00, 01, 10, 11 in order, with lu_a/lu_b held.
//   - OUT + out_ready with op != 11 -> ISSUE with {sel2,sel1} incremented (2 cycles per further result).
//   - OUT + out_ready with op == 11 -> IDLE.
//   - Four results, four done_cnt increments per request; in_ready stays 0 until the last handshake.
// - LU_SWEEP_EN undefined: single-op behaviour as above; in_op is honoured.
// TESTING (bench models LU: s = op00 a^b, op01 ~(a^b), op10 a|b, op11 ~(a|b))
// - Reset mid-OUT -> next cycle out_valid=0, in_ready=1, done_cnt=0.
// - a=0101, b=0011, op=00, out_ready=1 -> out_valid two cycles after accept.
//   - Expect out_data=0110, out_op=00, done_cnt=1.
// - a=0101, b=0011, op=11, out_ready=0 for 5 cycles:
//   - out_data=1000 held stable throughout; in_ready=0 throughout.
//   - On release, done_cnt increments once.
// - Back-to-back ops 01 then 10 on a=1100, b=1010 with in_valid held high:
//   - Results 1001 then 1110; second accept occurs exactly in the IDLE cycle after the first handshake.
// - LU_SWEEP_EN, a=1100, b=0110, out_ready=1:
//   - Out sequence (op,data) = (00,1010) (01,0101) (10,1110) (11,0001), then in_ready=1.
// - CNT_W=2, 5 handshakes -> done_cnt=3 after 3rd and stays 3.

Source files
------------

// File: rtl/lu_issue_stage.sv
// lu_issue_stage
// Issue stage in front of the 4-function logic unit (xor/xnor/or/nor).
// Takes {a, b, op} over valid/ready, drives registered operands and selects
// into the LU, captures the LU result one cycle later and offers it
// downstream over valid/ready. One transaction is in flight at a time.
// Optional build macro: LU_SWEEP_EN -- each accepted request issues all four
// ops (00, 01, 10, 11) in order with the operands held, and in_op is ignored.
module lu_issue_stage #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic [WIDTH-1:0] lu_a,
  output logic [WIDTH-1:0] lu_b,
  output logic             lu_sel1,
  output logic             lu_sel2,
  input  logic [WIDTH-1:0] lu_s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_op,
  output logic [CNT_W-1:0] done_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t state;

  // Single FSM: state plus every registered output, including the handshake
  // flags, so nothing downstream sees a combinational path from the inputs.
  // NOTE: all state here is written with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      lu_a      <= '0;
      lu_b      <= '0;
      lu_sel1   <= 1'b0;
      lu_sel2   <= 1'b0;
      out_data  <= '0;
      out_op    <= 2'b00;
      done_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            lu_a <= in_a;
            lu_b <= in_b;
`ifdef LU_SWEEP_EN
            // A sweep always starts from op 00; the requested op is ignored.
            {lu_sel2, lu_sel1} <= 2'b00;
`else
            {lu_sel2, lu_sel1} <= in_op;
`endif
            in_ready <= 1'b0;
            state    <= ISSUE;
          end
        end

        ISSUE: begin
          // The LU has had a full cycle to settle on the registered operands.
          out_data  <= lu_s;
          out_op    <= {lu_sel2, lu_sel1};
          out_valid <= 1'b1;
          state     <= OUT;
        end

        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (done_cnt != '1) begin
              done_cnt <= done_cnt + CNT_W'(1);
            end
`ifdef LU_SWEEP_EN
            if (out_op != 2'b11) begin
              // Operands stay put; only the select advances to the next op.
              {lu_sel2, lu_sel1} <= out_op + 2'b01;
              state              <= ISSUE;
            end else begin
              in_ready <= 1'b1;
              state    <= IDLE;
            end
`else
            in_ready <= 1'b1;
            state    <= IDLE;
`endif
          end
        end

        default: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
